// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
// Optional watchdog is enabled with the SDRAM_ARB_TIMEOUT_EN macro (see sdram_arbiter.sv).
package sdram_arb_pkg;

  localparam int unsigned ADDR_W          = 25;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned DONE_LOW_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_e;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_sel_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Client (A/B) and controller-side signals of the SDRAM arbiter.
// slave is the arbiter's view; master is the surrounding clients plus controller.
interface sdram_arbiter_if;

  logic                              a_req;
  logic                              a_we;
  logic [sdram_arb_pkg::ADDR_W-1:0]  a_addr;
  logic [sdram_arb_pkg::DATA_W-1:0]  a_din;
  logic [sdram_arb_pkg::DATA_W-1:0]  a_dout;
  logic                              a_ack;

  logic                              b_req;
  logic                              b_we;
  logic [sdram_arb_pkg::ADDR_W-1:0]  b_addr;
  logic [sdram_arb_pkg::DATA_W-1:0]  b_din;
  logic [sdram_arb_pkg::DATA_W-1:0]  b_dout;
  logic                              b_ack;

  logic [sdram_arb_pkg::ADDR_W-1:0]  ram_addr;
  logic [sdram_arb_pkg::DATA_W-1:0]  ram_din;
  logic [sdram_arb_pkg::DATA_W-1:0]  ram_dout;
  logic                              ram_rd;
  logic                              ram_we;
  logic                              ram_ready;

  logic                              busy;

  modport slave (
    input  a_req, a_we, a_addr, a_din,
    output a_dout, a_ack,
    input  b_req, b_we, b_addr, b_din,
    output b_dout, b_ack,
    output ram_addr, ram_din, ram_rd, ram_we,
    input  ram_dout, ram_ready,
    output busy
  );

  modport master (
    output a_req, a_we, a_addr, a_din,
    input  a_dout, a_ack,
    output b_req, b_we, b_addr, b_din,
    input  b_dout, b_ack,
    input  ram_addr, ram_din, ram_rd, ram_we,
    output ram_dout, ram_ready,
    input  busy
  );

endinterface

// File: rtl/sdram_arb_grant.sv
// Combinational winner selection between the two request lines.
// Fixed B priority, or round-robin steered by the pointer held in the top module.
module sdram_arb_grant
  import sdram_arb_pkg::*;
#(
  parameter bit B_PRIORITY = 1'b1
) (
  input  logic      req_a,
  input  logic      req_b,
  input  port_sel_e ptr,
  output logic      gnt_valid,
  output port_sel_e gnt
);

  always_comb begin
    gnt = PORT_A;
    if (req_a && req_b) begin
      gnt = B_PRIORITY ? PORT_B : ptr;
    end else if (req_b) begin
      gnt = PORT_B;
    end
  end

  assign gnt_valid = req_a | req_b;

endmodule

// File: rtl/sdram_arbiter.sv
// Two-client arbiter turning level req/ack handshakes into edge-triggered SDRAM strobes.
// Define SDRAM_ARB_TIMEOUT_EN to add the ISSUE/WAIT watchdog and the sticky timeout output.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter bit          B_PRIORITY     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic           clk,
  input  logic           reset_n,
`ifdef SDRAM_ARB_TIMEOUT_EN
  output logic           timeout,
`endif
  sdram_arbiter_if.slave bus
);

  localparam logic [1:0] DoneCntInit = 2'(DONE_LOW_CYCLES - 1);

  arb_state_e        state_q;
  port_sel_e         sel_q;
  port_sel_e         ptr_q;
  port_sel_e         gnt;
  logic              gnt_valid;
  logic              we_q;
  logic [1:0]        done_cnt_q;

  logic              gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_din;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam logic [9:0] ToLimit = 10'(TIMEOUT_CYCLES);
  logic [9:0] to_cnt_q;
`else
  // Watchdog limit has no effect without the timeout feature.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^10'(TIMEOUT_CYCLES);
`endif

  sdram_arb_grant #(
    .B_PRIORITY(B_PRIORITY)
  ) u_grant (
    .req_a     (bus.a_req),
    .req_b     (bus.b_req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  always_comb begin
    gnt_we   = bus.a_we;
    gnt_addr = bus.a_addr;
    gnt_din  = bus.a_din;
    if (gnt == PORT_B) begin
      gnt_we   = bus.b_we;
      gnt_addr = bus.b_addr;
      gnt_din  = bus.b_din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sel_q        <= PORT_A;
      ptr_q        <= PORT_A;
      we_q         <= 1'b0;
      done_cnt_q   <= '0;
      bus.ram_rd   <= 1'b0;
      bus.ram_we   <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_din  <= '0;
      bus.a_dout   <= '0;
      bus.b_dout   <= '0;
      bus.a_ack    <= 1'b0;
      bus.b_ack    <= 1'b0;
      bus.busy     <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      timeout      <= 1'b0;
`endif
    end else begin
      bus.a_ack <= 1'b0;
      bus.b_ack <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Ready low covers controller init and refresh: hold off granting.
          if (bus.ram_ready && gnt_valid) begin
            sel_q        <= gnt;
            we_q         <= gnt_we;
            bus.ram_addr <= gnt_addr;
            bus.ram_din  <= gnt_din;
            bus.ram_we   <= gnt_we;
            bus.ram_rd   <= !gnt_we;
            bus.busy     <= 1'b1;
            state_q      <= ISSUE;
            if (!B_PRIORITY) begin
              ptr_q <= (ptr_q == PORT_A) ? PORT_B : PORT_A;
            end
`ifdef SDRAM_ARB_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
          end
        end
        ISSUE, WAIT: begin
          if (state_q == WAIT && bus.ram_ready) begin
            if (!we_q) begin
              if (sel_q == PORT_B) bus.b_dout <= bus.ram_dout;
              else                 bus.a_dout <= bus.ram_dout;
            end
            bus.a_ack  <= (sel_q == PORT_A);
            bus.b_ack  <= (sel_q == PORT_B);
            bus.ram_rd <= 1'b0;
            bus.ram_we <= 1'b0;
            done_cnt_q <= DoneCntInit;
            state_q    <= DONE;
`ifdef SDRAM_ARB_TIMEOUT_EN
          end else if (to_cnt_q == ToLimit) begin
            if (sel_q == PORT_B) bus.b_dout <= 8'hFF;
            else                 bus.a_dout <= 8'hFF;
            bus.a_ack  <= (sel_q == PORT_A);
            bus.b_ack  <= (sel_q == PORT_B);
            bus.ram_rd <= 1'b0;
            bus.ram_we <= 1'b0;
            timeout    <= 1'b1;
            done_cnt_q <= DoneCntInit;
            state_q    <= DONE;
`endif
          end else begin
            // Ready dropping in ISSUE is the controller acknowledging the strobe edge.
            if (state_q == ISSUE && !bus.ram_ready) begin
              state_q <= WAIT;
            end
`ifdef SDRAM_ARB_TIMEOUT_EN
            to_cnt_q <= to_cnt_q + 10'd1;
`endif
          end
        end
        DONE: begin
          if (done_cnt_q == '0) begin
            bus.busy <= 1'b0;
            state_q  <= IDLE;
          end else begin
            done_cnt_q <= done_cnt_q - 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
